// File: rtl/jk_excite_ctrl.sv
// Command side of a JK flip-flop register: accepts a target word, excites the bank
// toward it, checks the fed-back Q, and retries a bounded number of times.
module jk_excite_ctrl #(
    parameter int WIDTH      = 4,
    parameter int MAX_RETRY  = 2,
    parameter int USE_TOGGLE = 0,
    parameter int CNT_W      = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tgt_valid_i,
    output logic             tgt_ready_o,
    input  logic [WIDTH-1:0] tgt_data_i,
    input  logic [WIDTH-1:0] q_fb_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] attempts_o
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK
    } state_e;

    localparam logic [CNT_W-1:0] LAST_ATTEMPT = CNT_W'(MAX_RETRY + 1);

    state_e           state_q;
    logic [WIDTH-1:0] tgt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] attempts_q;
    logic [WIDTH-1:0] diff;

    assign cnt_d = cnt_q + CNT_W'(1);
    assign diff  = q_fb_i ^ tgt_q;

    // NOTE: j/k get a default before the branch so every path assigns them and no latch is inferred.
    always_comb begin
        j_o = '0;
        k_o = '0;
        if (state_q == DRIVE) begin
            if (USE_TOGGLE != 0) begin
                j_o = diff;
                k_o = diff;
            end else begin
                j_o = diff & tgt_q;
                k_o = diff & q_fb_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            attempts_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tgt_valid_i) begin
                        tgt_q   <= tgt_data_i;
                        cnt_q   <= '0;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    cnt_q   <= cnt_d;
                    state_q <= CHECK;
                end
                CHECK: begin
                    // cnt_q already counts the drive that just completed.
                    if (q_fb_i == tgt_q) begin
                        state_q    <= IDLE;
                        done_q     <= 1'b1;
                        attempts_q <= cnt_q;
                    end else if (cnt_q < LAST_ATTEMPT) begin
                        state_q <= DRIVE;
                    end else begin
                        state_q    <= IDLE;
                        err_q      <= 1'b1;
                        attempts_q <= cnt_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tgt_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign attempts_o  = attempts_q;

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Drives two controllers (set/reset and toggle excitation) against behavioural JK banks
// with stuck-at hooks; a queue scoreboard and a cycle model predict every response.
module tb_jk_excite_ctrl;

    localparam int W  = 4;
    localparam int MR = 2;
    localparam int CW = 2;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         tgt_valid = 1'b0;
    logic [W-1:0] tgt_data  = '0;

    logic [W-1:0] bank0 = '0, bank1 = '0;
    logic         pre_en = 1'b0;
    logic [W-1:0] pre_val = '0, stuck_mask = '0, stuck_val = '0;

    logic          ready0, busy0, done0, err0, ready1, busy1, done1, err1;
    logic [W-1:0]  j0, k0, j1, k1;
    logic [CW-1:0] att0, att1;

    int n_vec  = 0;
    int n_miss = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    jk_excite_ctrl #(.WIDTH(W), .MAX_RETRY(MR), .USE_TOGGLE(0), .CNT_W(CW)) dut0 (
        .clk_i(clk), .rst_i(rst), .tgt_valid_i(tgt_valid), .tgt_ready_o(ready0),
        .tgt_data_i(tgt_data), .q_fb_i(bank0), .j_o(j0), .k_o(k0), .busy_o(busy0),
        .done_o(done0), .err_o(err0), .attempts_o(att0)
    );

    jk_excite_ctrl #(.WIDTH(W), .MAX_RETRY(MR), .USE_TOGGLE(1), .CNT_W(CW)) dut1 (
        .clk_i(clk), .rst_i(rst), .tgt_valid_i(tgt_valid), .tgt_ready_o(ready1),
        .tgt_data_i(tgt_data), .q_fb_i(bank1), .j_o(j1), .k_o(k1), .busy_o(busy1),
        .done_o(done1), .err_o(err1), .attempts_o(att1)
    );

    // JK truth table: 00 hold, 01 reset, 10 set, 11 toggle; stuck bits override everything.
    function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                             input logic [W-1:0] k);
        return (j & k & ~q) | (j & ~k) | (~j & ~k & q);
    endfunction

    always @(posedge clk) begin
        bank0 <= ((pre_en ? pre_val : jk_next(bank0, j0, k0)) & ~stuck_mask) | (stuck_val & stuck_mask);
        bank1 <= ((pre_en ? pre_val : jk_next(bank1, j1, k1)) & ~stuck_mask) | (stuck_val & stuck_mask);
    end

    typedef struct {
        bit           is_err;
        int           att;
        logic [W-1:0] q;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int           m_rem = 0;
    bit           m_fin = 1'b0;
    bit           m_err = 1'b0;
    logic [W-1:0] m_tgt = '0;

    // Outcome model: an operation takes one drive if the bank can reach the target, else all drives.
    always @(posedge clk) begin : model
        exp_t         e;
        logic [W-1:0] reach;
        if (rst) begin
            if (m_rem != 0) begin
                sb0.delete(sb0.size() - 1);
                sb1.delete(sb1.size() - 1);
            end
            m_rem <= 0;
            m_fin <= 1'b0;
        end else begin
            m_fin <= (m_rem == 1);
            if (m_rem == 0) begin
                if (tgt_valid) begin
                    reach    = (tgt_data & ~stuck_mask) | (stuck_val & stuck_mask);
                    e.is_err = (reach != tgt_data);
                    e.att    = e.is_err ? MR + 1 : 1;
                    e.q      = reach;
                    sb0.push_back(e);
                    sb1.push_back(e);
                    m_rem <= 2 * e.att;
                    m_err <= e.is_err;
                    m_tgt <= tgt_data;
                end
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        bit   drive;
        exp_t e;
        if (mon_en) begin
            drive = (m_rem != 0) && (m_rem % 2 == 0);
            check("ready0", ready0, m_rem == 0);
            check("ready1", ready1, m_rem == 0);
            check("busy0", busy0, m_rem != 0);
            check("busy1", busy1, m_rem != 0);
            check("j0", j0, drive ? ((bank0 ^ m_tgt) & m_tgt) : '0);
            check("k0", k0, drive ? ((bank0 ^ m_tgt) & bank0) : '0);
            check("j1", j1, drive ? (bank1 ^ m_tgt) : '0);
            check("k1", k1, drive ? (bank1 ^ m_tgt) : '0);
            check("done0", done0, m_fin && !m_err);
            check("err0", err0, m_fin && m_err);
            check("done1", done1, m_fin && !m_err);
            check("err1", err1, m_fin && m_err);
            if (done0 || err0) begin
                if (sb0.size() == 0) begin
                    check("sb0_unexpected", 1, 0);
                end else begin
                    e = sb0.pop_front();
                    check("sb0_err", err0, e.is_err);
                    check("sb0_att", att0, e.att);
                    check("sb0_q", bank0, e.q);
                end
            end
            if (done1 || err1) begin
                if (sb1.size() == 0) begin
                    check("sb1_unexpected", 1, 0);
                end else begin
                    e = sb1.pop_front();
                    check("sb1_err", err1, e.is_err);
                    check("sb1_att", att1, e.att);
                    check("sb1_q", bank1, e.q);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic timed_out(input string what);
        n_vec++;
        n_miss++;
        $display("FAIL timeout_%s: no progress within 60 cycles, expected completion", what);
    endtask

    task automatic preload(input logic [W-1:0] v);
        pre_val = v;
        pre_en  = 1'b1;
        tick();
        pre_en  = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input bit hold);
        bit will;
        tgt_valid = 1'b1;
        tgt_data  = d;
        for (int i = 0; i < 60; i++) begin
            will = (m_rem == 0) && !rst;
            tick();
            if (will) begin
                if (!hold) begin
                    tgt_valid = 1'b0;
                    tgt_data  = W'($urandom);
                end
                return;
            end
        end
        timed_out("send");
        tgt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (m_rem == 0 && !m_fin) return;
            tick();
        end
        timed_out("idle");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        bit held;
        rst = 1'b1;
        pre_val = '0;
        pre_en = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        pre_en = 1'b0;
        rst = 1'b0;
        check("rst_att0", att0, 0);
        check("rst_att1", att1, 0);

        // Plain set from zero, and toggle-mode move from 1100 to 0110.
        send(4'b1010, 1'b0);
        wait_idle();
        check("t1_bank0", bank0, 4'b1010);
        check("t1_att0", att0, 1);
        preload(4'b1100);
        send(4'b0110, 1'b0);
        wait_idle();
        check("t2_bank1", bank1, 4'b0110);

        // Bit 0 stuck low: every retry is spent, then err.
        stuck_mask = 4'b0001;
        stuck_val  = 4'b0000;
        preload(4'b0000);
        send(4'b0001, 1'b0);
        wait_idle();
        check("t3_att0", att0, MR + 1);
        stuck_mask = '0;

        // Target already present.
        preload(4'b0101);
        send(4'b0101, 1'b0);
        wait_idle();
        check("t4_att0", att0, 1);

        // Back-to-back with tgt_valid held high.
        send(4'b0011, 1'b1);
        send(4'b1100, 1'b0);
        wait_idle();
        check("t5_bank0", bank0, 4'b1100);

        // Reset during CHECK aborts silently.
        preload(4'b0000);
        send(4'b0110, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_att0", att0, 0);
        send(4'b1001, 1'b0);
        wait_idle();
        check("t6_bank0", bank0, 4'b1001);

        held = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (!held) begin
                wait_idle();
                if ($urandom_range(1, 0) == 1) preload(W'($urandom));
                stuck_mask = ($urandom_range(3, 0) == 0) ? W'($urandom) : '0;
                stuck_val  = W'($urandom);
                if ($urandom_range(1, 0) == 1) tick();
            end
            held = ($urandom_range(1, 0) == 1);
            send(W'($urandom), held);
        end
        tgt_valid = 1'b0;
        wait_idle();
        tick();
        tick();
        check("sb0_drained", sb0.size(), 0);
        check("sb1_drained", sb1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
